tlul_host_adapter: RTL and testbench
====================================

# tlul_host_adapter

TL-UL initiator that converts a simple request/grant memory port into TL-UL A-channel requests and returns D-channel responses in order. It is the host-side counterpart to the register-block devices on the bus, such as gpio's u_reg. A test sequencer or small controller can drive peripheral registers with it, without a full core. It tracks up to MaxReqs in-flight transactions, allocates source IDs, and checks each response against the request that produced it.

## Interface
- MaxReqs, 2: maximum outstanding transactions; legal values 2, 4 or 8; SrcW = log2(MaxReqs).
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_i  in  1  host request valid; host holds req_i and all request fields stable until gnt_o.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  32  byte address; bits [1:0] ignored.
- we_i  in  1  1 = write, 0 = read.
- wdata_i  in  32  write data.
- be_i  in  4  write byte enables; ignored for reads.
- valid_o  out  1  response valid (single-cycle pulse per response).
- rdata_o  out  32  read data.
- err_o  out  1  response error, qualified by valid_o.
- busy_o  out  1  one or more transactions outstanding.
- tl_o  out  tlul_pkg::tl_h2d_t  TL-UL A channel plus d_ready.
- tl_i  in  tlul_pkg::tl_d2h_t  TL-UL D channel plus a_ready.

## Operation
- State:
  - cnt_q: outstanding count, 0..MaxReqs.
  - src_q: next source ID, SrcW bits, wraps MaxReqs-1 -> 0.
  - MaxReqs-entry in-order tracking FIFO. Each entry holds {source, we}, with rd_ptr/wr_ptr.
- A channel:
  - a_valid = req_i && (cnt_q < MaxReqs).
  - a_opcode:
    - Get (4) when !we_i.
    - PutFullData (0) when we_i && be_i == 4'hF.
    - PutPartialData (1) otherwise, including be_i == 0.
  - a_size = 2.
  - a_mask = we_i ? be_i : 4'hF.
  - a_address = {addr_i[31:2], 2'b00}.
  - a_data = we_i ? wdata_i : 0.
  - a_source = zero-extended src_q.
  - a_param = 0. a_user = tlul_pkg default.
- gnt_o = a_valid && a_ready.
- On gnt_o: push {src_q, we_i} into the FIFO, increment src_q, increment cnt_q.
- D channel:
  - d_ready tied to 1.
  - Each d_valid cycle produces valid_o = 1 in the same cycle.
- Response check when cnt_q > 0:
  - Pop the FIFO head.
  - err_o = d_error OR (d_source != head.source) OR (opcode mismatch).
  - Opcode mismatch: head.we requires AccessAck (0); !head.we requires AccessAckData (1).
  - rdata_o = d_data when !head.we and !err_o, else 0.
  - Decrement cnt_q.
- Unexpected response (d_valid while cnt_q == 0): valid_o = 1, err_o = 1, rdata_o = 0. No pop; counters unchanged.
- busy_o = (cnt_q != 0).
- Simultaneous grant and response in one cycle: push and pop both occur and cnt_q is unchanged. A request granted this cycle is never matched by a response in the same cycle.
- Full (cnt_q == MaxReqs): a_valid held 0, so gnt_o = 0 and req_i stalls. Responses still drain normally.

## Timing
- Reset values:
  - cnt_q = 0, src_q = 0, FIFO pointers 0.
  - gnt_o = 0, valid_o = 0, err_o = 0, rdata_o = 0, busy_o = 0.
  - tl_o.a_valid = 0 while req_i = 0.
- Request path is combinational: req_i -> a_valid -> gnt_o in the same cycle. No added latency.
- Response path is combinational: d_valid -> valid_o in the same cycle.
- Minimum round trip equals device latency: request granted in cycle N, response earliest in N+1.
- Reset asserted mid-operation clears all state immediately. Responses to pre-reset transactions arriving afterward are reported as unexpected (err_o = 1).
- Throughput: one request and one response per cycle sustained.

## Test plan
- Single read: req_i=1, we_i=0, addr_i=0x40000013, device returns AccessAckData with d_data=0xA5A5_0001 one cycle later.
  - a_address=0x40000010, a_opcode=4, a_mask=F, a_source=0.
  - valid_o=1, rdata_o=0xA5A50001, err_o=0.
- Writes: be_i=4'hF -> a_opcode=0. be_i=4'h3 -> a_opcode=1, a_mask=3. Both return AccessAck, so err_o=0 and rdata_o=0.
- Full stall (MaxReqs=2, device withholds responses): two grants occur with a_source 0 then 1. Third request gets a_valid=0, gnt_o=0, busy_o=1 until the first response. Grant then occurs with a_source 0 (wrap).
- Error cases:
  - d_error=1 -> err_o=1.
  - d_source=1 when head expects 0 -> err_o=1.
  - AccessAck returned for a read -> err_o=1, rdata_o=0.
- Unexpected response with cnt_q=0 -> valid_o=1, err_o=1, busy_o stays 0. Response plus grant in the same cycle -> cnt_q unchanged.
- Assert rst_ni low with 2 outstanding: busy_o=0 immediately. A late response after reset -> valid_o=1, err_o=1.

Source files
------------

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions shared by hosts and devices on the 32-bit bus.
package tlul_pkg;

    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_AIW = 8;
    localparam int unsigned TL_DBW = 4;
    localparam int unsigned TL_SZW = 2;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef logic [15:0] tl_user_t;
    localparam tl_user_t TL_A_USER_DEFAULT = '0;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        tl_user_t          a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic              d_sink;
        logic [TL_DW-1:0]  d_data;
        tl_user_t          d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_host_adapter.sv
// Request/grant host port to TL-UL initiator with in-order response tracking.
module tlul_host_adapter #(
    parameter int unsigned MaxReqs = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    output logic               gnt_o,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    input  logic [31:0]        wdata_i,
    input  logic [3:0]         be_i,
    output logic               valid_o,
    output logic [31:0]        rdata_o,
    output logic               err_o,
    output logic               busy_o,
    output tlul_pkg::tl_h2d_t  tl_o,
    input  tlul_pkg::tl_d2h_t  tl_i
);

    localparam int unsigned SrcW = $clog2(MaxReqs);
    localparam logic [SrcW:0] MaxCnt = MaxReqs[SrcW:0];

    logic [SrcW:0]   cnt_q, cnt_d;
    logic [SrcW-1:0] src_q;
    logic [SrcW-1:0] rd_ptr_q, wr_ptr_q;
    logic [SrcW-1:0] fifo_src_q [MaxReqs];
    logic            fifo_we_q  [MaxReqs];

    logic                         a_valid;
    logic                         push, pop;
    logic [SrcW-1:0]              head_src;
    logic                         head_we;
    logic [tlul_pkg::TL_AIW-1:0]  exp_src;
    logic [2:0]                   exp_op;

    logic unused_inputs;
    assign unused_inputs = ^{addr_i[1:0], tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

    // A channel
    always_comb begin
        a_valid = req_i && (cnt_q < MaxCnt);
        gnt_o   = a_valid && tl_i.a_ready;

        tl_o           = '0;
        tl_o.a_valid   = a_valid;
        tl_o.a_opcode  = !we_i          ? tlul_pkg::Get :
                         (be_i == 4'hF) ? tlul_pkg::PutFullData : tlul_pkg::PutPartialData;
        tl_o.a_param   = 3'h0;
        tl_o.a_size    = 2'd2;
        tl_o.a_source  = '0;
        tl_o.a_source[SrcW-1:0] = src_q;
        tl_o.a_address = {addr_i[31:2], 2'b00};
        tl_o.a_mask    = we_i ? be_i : 4'hF;
        tl_o.a_data    = we_i ? wdata_i : '0;
        tl_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
        tl_o.d_ready   = 1'b1;
    end

    // D channel: every response is matched against the oldest outstanding request
    always_comb begin
        head_src = fifo_src_q[rd_ptr_q];
        head_we  = fifo_we_q[rd_ptr_q];
        exp_src  = '0;
        exp_src[SrcW-1:0] = head_src;
        exp_op   = head_we ? tlul_pkg::AccessAck : tlul_pkg::AccessAckData;

        valid_o = tl_i.d_valid;
        err_o   = 1'b0;
        rdata_o = '0;
        if (tl_i.d_valid) begin
            if (cnt_q == '0) begin
                err_o = 1'b1;
            end else begin
                err_o = tl_i.d_error || (tl_i.d_source != exp_src) || (tl_i.d_opcode != exp_op);
                if (!head_we && !err_o) begin
                    rdata_o = tl_i.d_data;
                end
            end
        end
    end

    assign push   = gnt_o;
    assign pop    = tl_i.d_valid && (cnt_q != '0);
    assign busy_o = (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            src_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                src_q    <= src_q + 1'b1;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Entries are only read while cnt_q says they are valid, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_src_q[wr_ptr_q] <= src_q;
            fifo_we_q[wr_ptr_q]  <= we_i;
        end
    end

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Randomized bench for tlul_host_adapter against a queue-based transaction model.
module tb_tlul_host_adapter;

    localparam int unsigned MaxReqs = 2;

    logic              clk_i;
    logic              rst_ni;
    logic              req_i;
    logic              gnt_o;
    logic [31:0]       addr_i;
    logic              we_i;
    logic [31:0]       wdata_i;
    logic [3:0]        be_i;
    logic              valid_o;
    logic [31:0]       rdata_o;
    logic              err_o;
    logic              busy_o;
    tlul_pkg::tl_h2d_t tl_o;
    tlul_pkg::tl_d2h_t tl_i;

    tlul_host_adapter #(
        .MaxReqs (MaxReqs)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .gnt_o   (gnt_o),
        .addr_i  (addr_i),
        .we_i    (we_i),
        .wdata_i (wdata_i),
        .be_i    (be_i),
        .valid_o (valid_o),
        .rdata_o (rdata_o),
        .err_o   (err_o),
        .busy_o  (busy_o),
        .tl_o    (tl_o),
        .tl_i    (tl_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned src;
        bit          we;
    } txn_t;

    txn_t        out_q[$];
    int unsigned next_src;
    int unsigned n_checks;
    int unsigned n_pass;
    logic        last_gnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle at posedge+1, check at the falling edge, advance the model.
    task automatic cycle(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input logic dv,
                         input logic [2:0] dop, input logic [7:0] dsrc, input logic [31:0] dd,
                         input logic derr, input logic ar);
        txn_t        head;
        logic        exp_avalid;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [2:0]  exp_op;
        req_i   = req;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wdata;
        be_i    = be;
        tl_i          = '0;
        tl_i.a_ready  = ar;
        tl_i.d_valid  = dv;
        tl_i.d_opcode = dop;
        tl_i.d_source = dsrc;
        tl_i.d_data   = dd;
        tl_i.d_error  = derr;
        #4;
        exp_avalid = req && (out_q.size() < MaxReqs);
        last_gnt   = exp_avalid && ar;
        check("a_valid", tl_o.a_valid, exp_avalid);
        check("gnt", gnt_o, last_gnt);
        check("busy", busy_o, out_q.size() != 0);
        check("valid", valid_o, dv);
        check("d_ready", tl_o.d_ready, 1'b1);
        if (req) begin
            exp_op = !we ? 3'd4 : (be == 4'hF ? 3'd0 : 3'd1);
            check("a_opcode", tl_o.a_opcode, exp_op);
            check("a_address", tl_o.a_address, addr & 32'hFFFF_FFFC);
            check("a_mask", tl_o.a_mask, we ? be : 4'hF);
            check("a_data", tl_o.a_data, we ? wdata : 32'h0);
            check("a_source", tl_o.a_source, next_src);
            check("a_size", tl_o.a_size, 2);
            check("a_param_user", {tl_o.a_param, tl_o.a_user}, 0);
        end
        if (dv) begin
            if (out_q.size() == 0) begin
                exp_err   = 1'b1;
                exp_rdata = 32'h0;
            end else begin
                head      = out_q[0];
                exp_err   = derr || (dsrc != 8'(head.src)) || (dop != (head.we ? 3'd0 : 3'd1));
                exp_rdata = (!head.we && !exp_err) ? dd : 32'h0;
            end
            check("err", err_o, exp_err);
            check("rdata", rdata_o, exp_rdata);
        end
        if (dv && out_q.size() > 0) begin
            void'(out_q.pop_front());
        end
        if (last_gnt) begin
            out_q.push_back('{src: next_src, we: we});
            next_src = (next_src + 1) % MaxReqs;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic host(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
        cycle(1'b1, we, addr, wdata, be, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic rsp(input logic [2:0] dop, input logic [7:0] dsrc, input logic [31:0] dd,
                       input logic derr);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, dop, dsrc, dd, derr, 1'b1);
    endtask

    task automatic mid_reset();
        req_i  = 1'b0;
        tl_i   = '0;
        rst_ni = 1'b0;
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_gnt", gnt_o, 1'b0);
        check("rst_valid", valid_o, 1'b0);
        out_q.delete();
        next_src = 0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    logic        h_req, h_we, r_dv, r_derr, r_ar;
    logic [31:0] h_addr, h_wd, r_dd;
    logic [3:0]  h_be;
    logic [2:0]  r_op;
    logic [7:0]  r_src;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        next_src = 0;
        last_gnt = 1'b0;
        rst_ni   = 1'b0;
        req_i    = 1'b0;
        we_i     = 1'b0;
        addr_i   = '0;
        wdata_i  = '0;
        be_i     = '0;
        tl_i     = '0;
        repeat (2) @(posedge clk_i);
        #5;
        check("reset_gnt", gnt_o, 1'b0);
        check("reset_valid", valid_o, 1'b0);
        check("reset_err", err_o, 1'b0);
        check("reset_rdata", rdata_o, 32'h0);
        check("reset_busy", busy_o, 1'b0);
        check("reset_a_valid", tl_o.a_valid, 1'b0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Single read, then full and partial writes; last response overlaps a grant
        host(1'b0, 32'h4000_0013, 32'h0, 4'h0);
        rsp(3'd1, 8'd0, 32'hA5A5_0001, 1'b0);
        host(1'b1, 32'h4000_0104, 32'h1122_3344, 4'hF);
        cycle(1'b1, 1'b1, 32'h4000_0108, 32'h5566_7788, 4'h3, 1'b1, 3'd0, 8'd1, 32'h0, 1'b0, 1'b1);
        rsp(3'd0, 8'd0, 32'h0, 1'b0);

        // Fill to MaxReqs, stall, drain one, then the held request is granted
        host(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        host(1'b0, 32'h0000_0024, 32'h0, 4'h0);
        host(1'b0, 32'h0000_0028, 32'h0, 4'h0);
        host(1'b0, 32'h0000_0028, 32'h0, 4'h0);
        cycle(1'b1, 1'b0, 32'h0000_0028, 32'h0, 4'h0, 1'b1, 3'd1, 8'd1, 32'hDEAD_0001, 1'b0, 1'b1);
        host(1'b0, 32'h0000_0028, 32'h0, 4'h0);

        // Error responses: d_error, wrong source, AccessAck for a read, unexpected
        rsp(3'd1, 8'd0, 32'h1234_5678, 1'b1);
        rsp(3'd1, 8'd0, 32'h1234_5678, 1'b0);
        host(1'b0, 32'h0000_0030, 32'h0, 4'h0);
        rsp(3'd0, 8'd0, 32'hFFFF_FFFF, 1'b0);
        rsp(3'd1, 8'd0, 32'hCAFE_F00D, 1'b0);

        // Reset with two outstanding, then a late response
        host(1'b1, 32'h0000_0040, 32'h0000_00AA, 4'h1);
        host(1'b0, 32'h0000_0044, 32'h0, 4'h0);
        mid_reset();
        rsp(3'd0, 8'd1, 32'h0, 1'b0);

        // Random traffic: host holds a request until granted; device responds in order
        h_req = 1'b0;
        h_we  = 1'b0;
        h_addr = '0;
        h_wd  = '0;
        h_be  = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!h_req && $urandom_range(99) < 70) begin
                h_req  = 1'b1;
                h_we   = 1'($urandom);
                h_addr = $urandom;
                h_wd   = $urandom;
                h_be   = 4'($urandom);
                if ($urandom_range(3) == 0) h_be = 4'hF;
            end
            r_ar   = $urandom_range(99) < 80;
            r_dv   = 1'b0;
            r_op   = 3'd0;
            r_src  = 8'd0;
            r_dd   = $urandom;
            r_derr = 1'b0;
            if (out_q.size() > 0 && $urandom_range(99) < 50) begin
                r_dv  = 1'b1;
                r_src = 8'(out_q[0].src);
                r_op  = out_q[0].we ? 3'd0 : 3'd1;
                case ($urandom_range(19))
                    0: r_derr = 1'b1;
                    1: r_src  = r_src ^ 8'd1;
                    2: r_op   = out_q[0].we ? 3'd1 : 3'd0;
                    default: ;
                endcase
            end else if (out_q.size() == 0 && $urandom_range(99) < 5) begin
                r_dv  = 1'b1;
                r_op  = 3'($urandom_range(1));
                r_src = 8'($urandom_range(MaxReqs - 1));
            end
            cycle(h_req, h_we, h_addr, h_wd, h_be, r_dv, r_op, r_src, r_dd, r_derr, r_ar);
            if (last_gnt) h_req = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
